// File: rtl/contador_programa.sv
// contador_programa: ARM fetch-path program counter with branch redirect and imem request handshake.
// Latency: branch_valid -> new pc in 1 cycle; imem_ready -> fetch_valid in 0 cycles (combinational).
// Backpressure: pc and imem_req hold until imem_ready; stall drops the request and freezes the pc.
// Optional feature macro: CONTADOR_LINK_EN (BL link address output); default build ties link outputs to 0.
module contador_programa #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [31:0] PIPE_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        branch_link,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        redirect,
  output logic        link_valid,
  output logic [31:0] link_addr
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] target_sum;
  logic [31:0] target;
  logic        branch_take;

  // Branch target: PC read-ahead plus aligned offset, wrapping mod 2^32, forced word-aligned.
  always_comb begin
    target_sum = branch_pc + PIPE_OFFSET + branch_offset;
    target     = {target_sum[31:2], 2'b00};
  end

  // Next-state and request decode; reset suppresses any request in its own cycle.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      S_BOOT: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        imem_req = ~stall;
        if (stall) begin
          state_next = S_STALL;
        end
      end
      S_STALL: begin
        if (!stall) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  // Handshake completion and branch acceptance (branches are ignored while booting or in reset).
  always_comb begin
    fetch_valid = imem_req & imem_ready;
    branch_take = branch_valid & (state != S_BOOT) & ~reset;
  end

  // PC selection: a branch wins over the sequential step even if the fetch was accepted.
  always_comb begin
    pc_next = pc;
    if (branch_take) begin
      pc_next = target;
    end else if (fetch_valid) begin
      pc_next = pc + PC_STEP;
    end
  end

  // State, pc and redirect pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      redirect <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redirect <= branch_take;
    end
  end

`ifdef CONTADOR_LINK_EN
  logic        link_valid_q;
  logic [31:0] link_addr_q;
  logic        link_take;

  // A link is produced only by an accepted BL.
  always_comb begin
    link_take = branch_take & branch_link;
  end

  // One-cycle link pulse with the return address; the address reads 0 when no link is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'h0000_0000;
    end else begin
      link_valid_q <= link_take;
      link_addr_q  <= link_take ? (branch_pc + 32'd4) : 32'h0000_0000;
    end
  end

  // Drive the link outputs from their registers.
  always_comb begin
    link_valid = link_valid_q;
    link_addr  = link_addr_q;
  end
`else
  logic unused_branch_link;

  // Link feature absent: outputs tied off, BL flag has no effect.
  always_comb begin
    link_valid         = 1'b0;
    link_addr          = 32'h0000_0000;
    unused_branch_link = branch_link;
  end
`endif

endmodule

// File: tb/tb_contador_programa.sv
// Directed, table-driven bench for contador_programa: per-cycle input/expected-output records
// plus a hand-written sequential-fetch run. Link expectations follow CONTADOR_LINK_EN.
module tb_contador_programa;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic        branch_link;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        fetch_valid;
  logic        redirect;
  logic        link_valid;
  logic [31:0] link_addr;

  int n_cmp = 0;
  int n_bad = 0;

  contador_programa dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_link  (branch_link),
    .branch_pc    (branch_pc),
    .branch_offset(branch_offset),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .imem_req     (imem_req),
    .fetch_valid  (fetch_valid),
    .redirect     (redirect),
    .link_valid   (link_valid),
    .link_addr    (link_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs driven in this cycle, outputs expected in this same cycle (before the edge).
  typedef struct {
    logic        rst;
    logic        stl;
    logic        bv;
    logic        bl;
    logic [31:0] bpc;
    logic [31:0] boff;
    logic        rdy;
    logic [31:0] pc;
    logic        req;
    logic        fv;
    logic        rd;
    logic        lk;
    logic [31:0] la;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic bv, input logic bl,
                              input logic [31:0] bpc, input logic [31:0] boff, input logic rdy,
                              input logic [31:0] epc, input logic req, input logic fv,
                              input logic rd, input logic lk, input logic [31:0] la);
    vec_t v;
    v.rst = rst; v.stl = stl; v.bv = bv; v.bl = bl; v.bpc = bpc; v.boff = boff; v.rdy = rdy;
    v.pc = epc; v.req = req; v.fv = fv; v.rd = rd; v.lk = lk; v.la = la;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h want %h", row, nm, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic bv, input logic bl,
                       input logic [31:0] bpc, input logic [31:0] boff, input logic rdy);
    @(negedge clk);
    reset = rst; stall = stl; branch_valid = bv; branch_link = bl;
    branch_pc = bpc; branch_offset = boff; imem_ready = rdy;
    #2;
  endtask

  task automatic check_outputs(input int row, input logic [31:0] epc, input logic req,
                               input logic fv, input logic rd, input logic lk, input logic [31:0] la);
    logic        exp_lv;
    logic [31:0] exp_la;
`ifdef CONTADOR_LINK_EN
    exp_lv = lk;
    exp_la = lk ? la : 32'h0;
`else
    exp_lv = 1'b0;
    exp_la = 32'h0;
`endif
    chk("pc", row, pc, epc);
    chk("imem_req", row, {31'b0, imem_req}, {31'b0, req});
    chk("fetch_valid", row, {31'b0, fetch_valid}, {31'b0, fv});
    chk("redirect", row, {31'b0, redirect}, {31'b0, rd});
    chk("link_valid", row, {31'b0, link_valid}, {31'b0, exp_lv});
    chk("link_addr", row, link_addr, exp_la);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_link = 1'b0;
    branch_pc = 32'h0; branch_offset = 32'h0; imem_ready = 1'b1;

    //                rst stl bv bl bpc           boff          rdy  pc            req fv rd lk la
    // reset held: pc at RESET_PC, everything quiet
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        1,   32'h0,        0, 0, 0, 0, 32'h0));
    // release with ready held: boot bubble, then 0,4,8,C
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h0,        0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h4,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h8,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'hC,        1, 1, 0, 0, 32'h0));
    // memory not ready for 3 cycles at 0x10: request and pc hold
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h10,       1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h10,       1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h10,       1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h10,       1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h14,       1, 0, 0, 0, 32'h0));
    // backward branch 0x20 + 8 - 8 with ready: target wins over increment
    vecs.push_back(mk(0, 0, 1, 0, 32'h20,       32'hFFFF_FFF8, 1,  32'h14,       1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h20,       1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h20,       1, 0, 0, 0, 32'h0));
    // back-to-back branches: redirect each cycle, last one wins
    vecs.push_back(mk(0, 0, 1, 0, 32'h80,       32'h10,       0,   32'h20,       1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h200,      32'h0,        0,   32'h98,       1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h208,      1, 1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h20C,      1, 0, 0, 0, 32'h0));
    // branch together with stall: target loaded, no request until stall clears
    vecs.push_back(mk(0, 1, 1, 0, 32'h100,      32'h40,       1,   32'h20C,      0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,        1,   32'h148,      0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,        1,   32'h148,      0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h148,      0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h148,      1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h14C,      1, 0, 0, 0, 32'h0));
    // reset, then a branch during the boot cycle is ignored
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        1,   32'h14C,      0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h400,      32'h0,        1,   32'h0,        0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h0,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h0,        1, 0, 0, 0, 32'h0));
    // misaligned sum 0x3+8+4=0xF is forced down to 0xC
    vecs.push_back(mk(0, 0, 1, 0, 32'h3,        32'h4,        0,   32'h0,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'hC,        1, 0, 1, 0, 32'h0));
    // BL at 0x40: link pulse with 0x44 one cycle later (when the feature is built in)
    vecs.push_back(mk(0, 0, 1, 1, 32'h40,       32'h100,      0,   32'hC,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h148,      1, 0, 1, 1, 32'h44));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h148,      1, 0, 0, 0, 32'h0));
    // target arithmetic wraps: 0xFFFF_FFF0 + 8 + 0x10 -> 0x8
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h10,      0,   32'h148,      1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0,   32'h8,        1, 0, 1, 0, 32'h0));
    // pc wrap: 0xFFFF_FFFC plus an accepted fetch -> 0
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFF4, 32'h0,       0,   32'h8,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'hFFFF_FFFC, 1, 1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h0,        1, 1, 0, 0, 32'h0));
    // reset asserted mid-stall with a BL on the same cycle: all discarded
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,        1,   32'h4,        0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h500,      32'h0,        1,   32'h4,        0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h0,        0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1,   32'h0,        1, 1, 0, 0, 32'h0));

    // Two cycles of reset to bring the design out of its power-up unknown state.
    drive(1, 0, 0, 0, 32'h0, 32'h0, 1);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].bv, vecs[i].bl, vecs[i].bpc, vecs[i].boff, vecs[i].rdy);
      check_outputs(i, vecs[i].pc, vecs[i].req, vecs[i].fv, vecs[i].rd, vecs[i].lk, vecs[i].la);
    end

    // Hand-written run: uninterrupted accepted fetches continue from 0x4 in steps of 4.
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
      check_outputs(100 + k, 32'h4 + 32'(4 * k), 1, 1, 0, 0, 32'h0);
    end

    // Hand-written: stall with ready high freezes pc; release shows one idle cycle before the request.
    drive(0, 1, 0, 0, 32'h0, 32'h0, 1);
    check_outputs(200, 32'h24, 0, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 32'h0, 1);
    check_outputs(201, 32'h24, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
    check_outputs(202, 32'h24, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
    check_outputs(203, 32'h24, 1, 1, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    check_outputs(204, 32'h28, 1, 0, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
